// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video_capture raster-to-framebuffer block.
package video_capture_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        VBLANK = 2'd2
    } state_t;

    localparam int DEF_MAX_W = 256;
    localparam int DEF_MAX_H = 256;

    // Width of the internal x/y raster counters; wide enough to run past MAX_W/MAX_H.
    localparam int CNT_W = 16;

    function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vcap_geom.sv
// Geometry latches for video_capture: last line width and last frame height.
// Only instantiated when VIDEO_CAPTURE_GEOM_EN is defined.
module vcap_geom
    import video_capture_pkg::*;
#(
    parameter int CW = CNT_W,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          line_edge,
    input  logic          frame_edge,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          hs,
    input  logic          vs,
    output logic [HW-1:0] line_width,
    output logic [HW-1:0] frame_height
);

    // Captured sync levels, reserved for a later polarity check.
    logic [1:0] sync_unused_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            line_width    <= '0;
            frame_height  <= '0;
            sync_unused_q <= '0;
        end else if (ce_pix) begin
            sync_unused_q <= {hs, vs};
            if (line_edge) begin
                line_width <= x[HW-1:0];
            end
            // A line still holding pixels at frame end has not been counted in y yet.
            if (frame_edge) begin
                frame_height <= y[HW-1:0] + {{(HW-1){1'b0}}, |x};
            end
        end
    end

endmodule

// File: rtl/video_capture.sv
// Samples the video raster on the pixel clock and emits addressed framebuffer writes.
// Optional geometry outputs are built when VIDEO_CAPTURE_GEOM_EN is defined.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int MAX_W  = DEF_MAX_W,
    parameter int MAX_H  = DEF_MAX_H,
    parameter int ADDR_W = 16
) (
    input  logic              clk_4,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [7:0]        vga_r,
    input  logic [7:0]        vga_g,
    input  logic [7:0]        vga_b,
    input  logic              vga_hb,
    input  logic              vga_vb,
    input  logic              vga_hs,
    input  logic              vga_vs,
    output logic              pix_wr,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_data,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              clip_err,
    output logic [ADDR_W/2-1:0] line_width,
    output logic [ADDR_W/2-1:0] frame_height,
    output logic [1:0]        fsm_state
);

    localparam int XB = $clog2(MAX_W);
    localparam int YB = $clog2(MAX_H);
    localparam logic [31:0] MAX_W_L = MAX_W;
    localparam logic [31:0] MAX_H_L = MAX_H;
    localparam logic [CNT_W-1:0] LIM_X = MAX_W_L[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LIM_Y = MAX_H_L[CNT_W-1:0];

    // pix_wr is a valid-only strobe: there is no ready, so every cycle with pix_wr=1
    // carries one write (pix_addr/pix_data) that the consumer must accept.

    state_t           state, state_next;
    logic             hb_d, vb_d, primed;
    logic [CNT_W-1:0] x, y;
    logic             hb_rise, vb_rise, vb_fall;
    logic             frame_end, line_end, pix_act, in_range;

    assign hb_rise   = vga_hb & ~hb_d;
    assign vb_rise   = vga_vb & ~vb_d;
    assign vb_fall   = ~vga_vb & vb_d;
    assign in_range  = (x < LIM_X) && (y < LIM_Y);
    assign fsm_state = state;

    // The vb reset value of 1 would fake a falling edge out of reset; leaving SYNC
    // therefore needs at least one real sample (primed) so a partial frame is skipped.
    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        line_end   = 1'b0;
        pix_act    = 1'b0;
        unique case (state)
            SYNC:    if (ce_pix && primed && vb_fall) state_next = ACTIVE;
            ACTIVE: begin
                if (ce_pix && vb_rise) begin
                    state_next = VBLANK;
                    frame_end  = 1'b1;
                end else if (ce_pix && hb_rise) begin
                    line_end = 1'b1;
                end
            end
            VBLANK:  if (ce_pix && vb_fall) state_next = ACTIVE;
            default: state_next = SYNC;
        endcase
        pix_act = ce_pix && !vga_hb && !vga_vb && (state_next == ACTIVE);
    end

    always_ff @(posedge clk_4) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_4) begin
        if (reset) begin
            hb_d        <= 1'b1;
            vb_d        <= 1'b1;
            primed      <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_wr      <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            clip_err    <= 1'b0;
        end else begin
            pix_wr     <= 1'b0;
            frame_done <= 1'b0;
            if (ce_pix) begin
                hb_d   <= vga_hb;
                vb_d   <= vga_vb;
                primed <= 1'b1;
                if (frame_end) begin
                    x           <= '0;
                    y           <= '0;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                end else if (line_end) begin
                    x <= '0;
                    if (y != '1) y <= y + 1'b1;
                end else if (pix_act) begin
                    if (x != '1) x <= x + 1'b1;
                    if (in_range) begin
                        pix_wr   <= 1'b1;
                        pix_addr <= {y[YB-1:0], x[XB-1:0]};
                        pix_data <= pack_rgb(vga_r, vga_g, vga_b);
                    end else begin
                        clip_err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef VIDEO_CAPTURE_GEOM_EN
    logic geom_line;
    assign geom_line = ce_pix && (state == ACTIVE) && hb_rise;

    vcap_geom #(
        .CW(CNT_W),
        .HW(ADDR_W/2)
    ) u_geom (
        .clk         (clk_4),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .line_edge   (geom_line),
        .frame_edge  (frame_end),
        .x           (x),
        .y           (y),
        .hs          (vga_hs),
        .vs          (vga_vs),
        .line_width  (line_width),
        .frame_height(frame_height)
    );
`else
    logic unused_sync;
    assign unused_sync  = ^{vga_hs, vga_vs};
    assign line_width   = '0;
    assign frame_height = '0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Directed testbench for video_capture: raster capture, clipping, ce gating, frames and reset.
module tb_video_capture;
    import video_capture_pkg::*;

`ifdef VIDEO_CAPTURE_GEOM_EN
    localparam logic [7:0] EXP_LW = 8'd4;
    localparam logic [7:0] EXP_FH = 8'd3;
`else
    localparam logic [7:0] EXP_LW = 8'd0;
    localparam logic [7:0] EXP_FH = 8'd0;
`endif

    logic        clk_4 = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        vga_hb = 1'b1, vga_vb = 1'b1, vga_hs = 1'b0, vga_vs = 1'b0;
    logic        pix_wr, frame_done, clip_err;
    logic [15:0] pix_addr, frame_count;
    logic [23:0] pix_data;
    logic [7:0]  line_width, frame_height;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    logic [15:0] wr_addr_q[$];
    logic [23:0] wr_data_q[$];
    logic [39:0] exp_q[$];
    int fd_cnt = 0;
    int overlap_cnt = 0;

    video_capture dut (
        .clk_4(clk_4), .reset(reset), .ce_pix(ce_pix),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hb(vga_hb), .vga_vb(vga_vb), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .pix_wr(pix_wr), .pix_addr(pix_addr), .pix_data(pix_data),
        .frame_done(frame_done), .frame_count(frame_count), .clip_err(clip_err),
        .line_width(line_width), .frame_height(frame_height), .fsm_state(fsm_state)
    );

    always #5 clk_4 = ~clk_4;

    // Driver: apply one pixel, advance one edge, record what the DUT emitted.
    task automatic step(input logic ce, input logic hb, input logic vb,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        ce_pix = ce; vga_hb = hb; vga_vb = vb; vga_hs = hb; vga_vs = vb;
        vga_r = r; vga_g = g; vga_b = b;
        @(posedge clk_4);
        #1;
        if (pix_wr === 1'b1) begin
            wr_addr_q.push_back(pix_addr);
            wr_data_q.push_back(pix_data);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (frame_done === 1'b1 && pix_wr === 1'b1) overlap_cnt++;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
    endtask

    task automatic send_vblank(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic send_line(input int w, input int yy);
        for (int i = 0; i < w; i++) step(1'b1, 1'b0, 1'b0, 8'(i), 8'(yy), 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic send_frame(input int w, input int h);
        for (int l = 0; l < h; l++) send_line(w, l);
    endtask

    // Scoreboard: expected writes for a w x h raster, tagged {addr, data}.
    task automatic expect_frame(input int w, input int h);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                exp_q.push_back({8'(yy), 8'(xx), 8'(xx), 8'(yy), 8'hA5});
    endtask

    task automatic test_reset();
        vga_vb = 1'b0;
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        reset = 1'b0;
        checks++; if (pix_wr !== 1'b0) begin errors++; $display("FAIL reset_pix_wr got %b exp 0", pix_wr); end
        checks++; if (pix_addr !== 16'h0) begin errors++; $display("FAIL reset_pix_addr got %h exp 0000", pix_addr); end
        checks++; if (pix_data !== 24'h0) begin errors++; $display("FAIL reset_pix_data got %h exp 000000", pix_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count got %h exp 0000", frame_count); end
        checks++; if (clip_err !== 1'b0) begin errors++; $display("FAIL reset_clip_err got %b exp 0", clip_err); end
        checks++; if (line_width !== 8'h0 || frame_height !== 8'h0) begin
            errors++; $display("FAIL reset_geom got lw=%h fh=%h exp 00/00", line_width, frame_height);
        end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
    endtask

    task automatic test_raster();
        logic [39:0] e;
        do_reset(); clear_mon();
        send_vblank(10);
        send_frame(4, 3);
        send_vblank(5);
        expect_frame(4, 3);
        checks++; if (wr_addr_q.size() != 12) begin
            errors++; $display("FAIL raster_count got %0d exp 12", wr_addr_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_addr_q.size() == 0) begin
                errors++; $display("FAIL raster_missing got none exp addr %h", e[39:24]);
            end else begin
                logic [15:0] ga;
                logic [23:0] gd;
                ga = wr_addr_q.pop_front();
                gd = wr_data_q.pop_front();
                if (ga !== e[39:24] || gd !== e[23:0]) begin
                    errors++; $display("FAIL raster_write got %h/%h exp %h/%h", ga, gd, e[39:24], e[23:0]);
                end
            end
        end
        checks++; if (fd_cnt != 1 || frame_count !== 16'd1) begin
            errors++; $display("FAIL raster_frame got pulses=%0d count=%0d exp 1/1", fd_cnt, frame_count);
        end
        checks++; if (line_width !== EXP_LW || frame_height !== EXP_FH) begin
            errors++; $display("FAIL raster_geom got %0d/%0d exp %0d/%0d", line_width, frame_height, EXP_LW, EXP_FH);
        end
    endtask

    task automatic test_mid_frame();
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        clear_mon();
        send_line(4, 0);
        send_line(4, 1);
        send_vblank(3);
        checks++; if (wr_addr_q.size() != 0 || fd_cnt != 0 || frame_count !== 16'd0) begin
            errors++; $display("FAIL mid_partial got wr=%0d pulses=%0d count=%0d exp 0/0/0",
                               wr_addr_q.size(), fd_cnt, frame_count);
        end
        clear_mon();
        send_frame(4, 3);
        checks++; if (frame_count !== 16'd0) begin
            errors++; $display("FAIL mid_count_before_end got %0d exp 0", frame_count);
        end
        send_vblank(3);
        checks++; if (wr_addr_q.size() != 12 || frame_count !== 16'd1) begin
            errors++; $display("FAIL mid_full got wr=%0d count=%0d exp 12/1", wr_addr_q.size(), frame_count);
        end
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 16'h0000) begin
            errors++; $display("FAIL mid_first_addr got %0d entries exp first 0000", wr_addr_q.size());
        end
    endtask

    task automatic test_clip();
        logic exp_clip;
        int   clip_bad;
        do_reset(); clear_mon();
        send_vblank(2);
        clip_bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i), 8'h00, 8'hA5);
            exp_clip = (i >= 256);
            checks++;
            if (clip_err !== exp_clip) begin
                errors++;
                if (clip_bad < 4) $display("FAIL clip_flag px=%0d got %b exp %b", i, clip_err, exp_clip);
                clip_bad++;
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        send_vblank(3);
        checks++; if (wr_addr_q.size() != 256) begin
            errors++; $display("FAIL clip_count got %0d exp 256", wr_addr_q.size());
        end
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== 16'h00FF) begin
            errors++; $display("FAIL clip_last_addr got %0d entries exp last 00ff", wr_addr_q.size());
        end
        checks++; if (clip_err !== 1'b1 || frame_count !== 16'd1) begin
            errors++; $display("FAIL clip_sticky got clip=%b count=%0d exp 1/1", clip_err, frame_count);
        end
    endtask

    task automatic test_ce_toggle();
        logic ce;
        do_reset(); clear_mon();
        send_vblank(2);
        for (int i = 0; i < 8; i++) begin
            ce = (i % 2 == 0);
            step(ce, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
            checks++;
            if (pix_wr !== ce) begin
                errors++; $display("FAIL ce_strobe cyc=%0d got %b exp %b", i, pix_wr, ce);
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        send_vblank(2);
        checks++; if (wr_addr_q.size() != 4) begin
            errors++; $display("FAIL ce_count got %0d exp 4", wr_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_q.size() <= i || wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== 24'h112233) begin
                errors++; $display("FAIL ce_addr idx=%0d got %0d entries exp addr %h data 112233",
                                   i, wr_addr_q.size(), 16'(i));
            end
        end
    endtask

    task automatic test_frames();
        do_reset(); clear_mon();
        send_vblank(2);
        for (int f = 0; f < 3; f++) begin
            send_frame(4, 3);
            send_vblank(1);
            checks++; if (frame_done !== 1'b1) begin
                errors++; $display("FAIL frames_pulse f=%0d got %b exp 1", f, frame_done);
            end
            repeat (3) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
            send_vblank(3);
        end
        checks++; if (fd_cnt != 3) begin
            errors++; $display("FAIL frames_pulse_cycles got %0d exp 3", fd_cnt);
        end
        checks++; if (frame_count !== 16'd3 || wr_addr_q.size() != 36) begin
            errors++; $display("FAIL frames_count got count=%0d wr=%0d exp 3/36", frame_count, wr_addr_q.size());
        end
        checks++; if (overlap_cnt != 0) begin
            errors++; $display("FAIL frames_overlap got %0d exp 0", overlap_cnt);
        end
        checks++; if (line_width !== EXP_LW || frame_height !== EXP_FH) begin
            errors++; $display("FAIL frames_geom got %0d/%0d exp %0d/%0d", line_width, frame_height, EXP_LW, EXP_FH);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_mon();
        send_vblank(2);
        send_line(4, 0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'hA5);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 8'hA5);
        reset = 1'b0;
        checks++; if (pix_wr !== 1'b0 || pix_addr !== 16'h0 || pix_data !== 24'h0) begin
            errors++; $display("FAIL rmid_outputs got wr=%b addr=%h data=%h exp 0/0000/000000", pix_wr, pix_addr, pix_data);
        end
        checks++; if (frame_done !== 1'b0 || clip_err !== 1'b0 || fsm_state !== 2'd0) begin
            errors++; $display("FAIL rmid_state got fd=%b clip=%b st=%0d exp 0/0/0", frame_done, clip_err, fsm_state);
        end
        clear_mon();
        step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        send_line(4, 2);
        send_vblank(3);
        checks++; if (wr_addr_q.size() != 0 || fd_cnt != 0 || frame_count !== 16'd0) begin
            errors++; $display("FAIL rmid_partial got wr=%0d pulses=%0d count=%0d exp 0/0/0",
                               wr_addr_q.size(), fd_cnt, frame_count);
        end
        send_frame(4, 3);
        send_vblank(2);
        checks++; if (wr_addr_q.size() != 12 || wr_addr_q[0] !== 16'h0000 || frame_count !== 16'd1) begin
            errors++; $display("FAIL rmid_resume got wr=%0d count=%0d exp 12/1", wr_addr_q.size(), frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_mid_frame();
        test_clip();
        test_ce_toggle();
        test_frames();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_capture.md
# video_capture

Downstream consumer of the Dottori-Kun video outputs in the Verilator top. It samples RGB, sync and blank on the 4 MHz pixel clock and turns the raster into a stream of addressed pixel writes for the simulator framebuffer. It also emits a per-frame completion pulse and a frame counter. All outputs are registered, so C++ harness code only reads stable values at clock edges.

## Interface
Parameters:
- MAX_W, 256, framebuffer width in pixels; power of two
- MAX_H, 256, framebuffer height in lines; power of two
- ADDR_W, 16, pixel address width; must equal log2(MAX_W)+log2(MAX_H)

Ports:
- clk_4  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; sample only when high
- vga_r / vga_g / vga_b  in  8 each  colour channels
- vga_hb / vga_vb  in  1 each  horizontal / vertical blank, active high
- vga_hs / vga_vs  in  1 each  sync; used only for the geometry feature
- pix_wr  out  1  one-cycle write strobe
- pix_addr  out  ADDR_W  {y, x}
- pix_data  out  24  {r, g, b}
- frame_done  out  1  one-cycle pulse at the end of each captured frame
- frame_count  out  16  completed frames; wraps at 0xFFFF -> 0
- clip_err  out  1  sticky: a pixel fell outside MAX_W×MAX_H
- line_width  out  ADDR_W/2  active pixels in the last line (geometry)
- frame_height  out  ADDR_W/2  active lines in the last frame (geometry)

## Operation
- FSM states:
  - SYNC: reset state. Ignore all pixels and wait for a falling edge of vga_vb.
  - ACTIVE: capture pixels.
  - VBLANK: raster is in vertical blank.
- Transitions:
  - SYNC -> ACTIVE on vb falling edge.
  - ACTIVE -> VBLANK on vb rising edge.
  - VBLANK -> ACTIVE on vb falling edge.
- Edge detection uses a 1-deep delayed copy of hb/vb, updated only on ce_pix cycles.
- In ACTIVE, on each ce_pix with hb=0 and vb=0:
  - if x<MAX_W and y<MAX_H: write pixel (x,y), then x+=1
  - otherwise: no write, set clip_err, and x still increments (saturates at all-ones)
- hb rising edge in ACTIVE: x:=0, y+=1 (saturating).
- vb rising edge (ACTIVE -> VBLANK):
  - pulse frame_done
  - frame_count+=1
  - x:=0, y:=0
- Pixels with hb=1 or vb=1 are never written.
- clip_err is cleared only by reset.
- If ce_pix=0, state, counters and delayed copies all hold.

## Timing
- Latency: a pixel sampled at edge N produces pix_wr/pix_addr/pix_data valid for exactly one cycle after edge N.
- pix_wr is a single-cycle pulse per written pixel. There is no back-pressure: the consumer must accept every strobe.
- frame_done is asserted in the cycle after the ce_pix edge on which vb was first seen high. It never coincides with a pix_wr for the same frame's last pixel.
- hb rising and vb rising on the same ce_pix cycle: the frame-end action wins. Set y:=0 (not y+1), pulse frame_done once.
- Reset values: FSM=SYNC, x=y=0, pix_wr=0, pix_addr=0, pix_data=0, frame_done=0, frame_count=0, clip_err=0, line_width=0, frame_height=0, delayed hb/vb=1.
- Reset asserted mid-frame: all state returns to reset values on the next edge. Capture resumes only after the next vb falling edge, so a partial frame is never reported.

## Configuration
- VIDEO_CAPTURE_GEOM_EN defined:
  - line_width latches the x count on each hb rising edge.
  - frame_height latches the y count (+1 if the current line held pixels) on each vb rising edge.
  - vga_hs/vga_vs are sampled for a future sync-polarity check; they have no output in this revision.
- VIDEO_CAPTURE_GEOM_EN undefined:
  - geometry logic is absent
  - line_width and frame_height are tied to 0
  - all other behaviour is identical

## Structure
- Shared package video_capture_pkg:
  - FSM state enum (SYNC, ACTIVE, VBLANK)
  - default MAX_W/MAX_H constants
  - pixel-packing function {r,g,b} -> 24 bits
- One sub-module, vcap_geom: the geometry latches. Instantiated only under VIDEO_CAPTURE_GEOM_EN.
- Edge detection and address/data registers live in the top module.

## Test plan
- Reset, then vb=1 for 10 pixels, vb=0 with a 4×3 active raster (hb=1 for 2 pixels between lines) -> 12 pix_wr strobes at addresses 0x0000..0x0003, 0x0100..0x0103, 0x0200..0x0203; no writes during hb.
- Start stimulus mid-frame (vb=0 out of reset) -> zero pix_wr until after the first vb rise and fall; frame_count stays 0 until the first full frame ends.
- Feed a 300-pixel-wide line with MAX_W=256 -> writes at x=0..255 only; clip_err=1 from pixel 256 onward and stays 1.
- ce_pix toggling 1,0,1,0 with constant input -> one write per ce_pix=1 cycle; addresses are contiguous.
- Run 3 frames -> three frame_done single-cycle pulses; frame_count=3; with VIDEO_CAPTURE_GEOM_EN, line_width=4 and frame_height=3.
- Assert reset for 1 cycle at pixel (2,1) -> all outputs 0 next cycle; no pix_wr until the next vb falling edge.
